// File: rtl/motor_dose_ctrl.sv
// motor_dose_ctrl: latches per-colour dose amounts and times each pigment motor run
module motor_dose_ctrl #(
  parameter int AMT_W          = 8,
  parameter int TICKS_PER_UNIT = 50000,
  parameter int PRE_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AMT_W-1:0] amt_r,
  input  logic [AMT_W-1:0] amt_y,
  input  logic [AMT_W-1:0] amt_b,
  input  logic [2:0]       Motores,
  output logic [2:0]       motor_drv,
  output logic [2:0]       flags,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             error
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, n_state;
  logic [2:0][AMT_W-1:0] amt_q, n_amt;
  logic [2:0] cur, n_cur, n_drv, n_flags;
  logic [AMT_W-1:0] n_rem, amt_sel;
  logic [PRE_W-1:0] pre, n_pre;
  logic n_err, one_hot, multi;
  logic [1:0] c;
  assign one_hot = (Motores != 3'b000) && ((Motores & (Motores - 3'd1)) == 3'b000);
  assign multi   = (Motores != 3'b000) && !one_hot;
  assign c       = Motores[2] ? 2'd2 : Motores[1] ? 2'd1 : 2'd0;
  assign amt_sel = amt_q[c];
  always_comb begin
    n_state = state;
    n_amt   = amt_q;
    n_cur   = cur;
    n_drv   = motor_drv;
    n_flags = flags;
    n_rem   = remaining;
    n_pre   = pre;
    n_err   = error;
    if (multi) begin
      n_err   = 1'b1;
      n_drv   = 3'b000;
      n_rem   = '0;
      n_pre   = '0;
      n_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            n_amt   = {amt_r, amt_y, amt_b};
            n_flags = 3'b000;
            n_err   = 1'b0;
          end else if (one_hot && (flags & Motores) == 3'b000) begin
            n_cur = Motores;
            if (amt_sel != '0) begin
              n_state = RUN;
              n_rem   = amt_sel;
              n_pre   = '0;
              n_drv   = Motores;
            end else begin
              n_flags = flags | Motores;
              n_state = DONE;
            end
          end
        end
        RUN: begin
          if (Motores != cur) begin
            n_drv   = 3'b000;
            n_rem   = '0;
            n_pre   = '0;
            n_state = IDLE;
          end else if (pre == PRE_W'(TICKS_PER_UNIT - 1)) begin
            n_pre = '0;
            n_rem = remaining - AMT_W'(1);
            if (remaining == AMT_W'(1)) begin
              n_drv   = 3'b000;
              n_flags = flags | cur;
              n_state = DONE;
            end
          end else begin
            n_pre = pre + PRE_W'(1);
          end
        end
        default: n_state = (Motores != cur) ? IDLE : DONE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      amt_q     <= '0;
      cur       <= 3'b000;
      motor_drv <= 3'b000;
      flags     <= 3'b000;
      remaining <= '0;
      pre       <= '0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= n_state;
      amt_q     <= n_amt;
      cur       <= n_cur;
      motor_drv <= n_drv;
      flags     <= n_flags;
      remaining <= n_rem;
      pre       <= n_pre;
      error     <= n_err;
      busy      <= (n_state == RUN);
    end
  end
endmodule

// File: tb/tb_motor_dose_ctrl.sv
// tb_motor_dose_ctrl: directed checks of dose timing, handoff, abort, error and async reset
module tb_motor_dose_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [7:0] amt_r = '0, amt_y = '0, amt_b = '0;
  logic [2:0] Motores = 3'b000;
  logic [2:0] motor_drv, flags;
  logic [7:0] remaining;
  logic busy, error;
  int total = 0, bad = 0, n;
  logic multi_seen = 1'b0;
  motor_dose_ctrl #(.AMT_W(8), .TICKS_PER_UNIT(4), .PRE_W(4)) dut (
    .clk(clk), .reset(reset), .load(load), .amt_r(amt_r), .amt_y(amt_y), .amt_b(amt_b),
    .Motores(Motores), .motor_drv(motor_drv), .flags(flags), .remaining(remaining),
    .busy(busy), .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if ($countones(motor_drv) > 1) multi_seen = 1'b1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [7:0] r, input logic [7:0] y, input logic [7:0] b);
    amt_r = r; amt_y = y; amt_b = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic count_on(input logic [2:0] m, output int cnt);
    cnt = 0;
    while (motor_drv == m && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask
  initial begin
    tick(); tick();
    chk("rst_drv", motor_drv, 0);
    chk("rst_flags", flags, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", error, 0);
    reset = 1'b0;
    tick();
    do_load(3, 2, 1);
    chk("load_flags", flags, 0);
    Motores = 3'b100;
    tick();
    chk("r_start_drv", motor_drv, 3'b100);
    chk("r_start_rem", remaining, 3);
    chk("r_start_busy", busy, 1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) chk("r_rem_c3", remaining, 3);
      if (i == 4) chk("r_rem_c4", remaining, 2);
      if (i == 8) chk("r_rem_c8", remaining, 1);
      if (i == 11) chk("r_drv_c11", motor_drv, 3'b100);
      if (i == 11) chk("r_flags_c11", flags, 3'b000);
    end
    chk("r_end_drv", motor_drv, 0);
    chk("r_end_flags", flags, 3'b100);
    chk("r_end_rem", remaining, 0);
    chk("r_end_busy", busy, 0);
    Motores = 3'b010;
    tick();
    chk("y_handoff_gap", motor_drv, 0);
    tick();
    chk("y_start", motor_drv, 3'b010);
    count_on(3'b010, n);
    chk("y_on_cycles", n, 8);
    chk("y_flags", flags, 3'b110);
    Motores = 3'b001;
    tick(); tick();
    chk("b_start", motor_drv, 3'b001);
    count_on(3'b001, n);
    chk("b_on_cycles", n, 4);
    chk("b_flags", flags, 3'b111);
    chk("never_two_hot", multi_seen, 0);
    Motores = 3'b000;
    tick();
    do_load(5, 0, 1);
    chk("reload_flags", flags, 0);
    Motores = 3'b010;
    tick();
    chk("zero_amt_flag", flags, 3'b010);
    chk("zero_amt_drv", motor_drv, 0);
    chk("zero_amt_busy", busy, 0);
    tick();
    chk("zero_amt_drv2", motor_drv, 0);
    Motores = 3'b000;
    tick();
    Motores = 3'b100;
    tick();
    chk("abort_start", motor_drv, 3'b100);
    repeat (6) tick();
    Motores = 3'b000;
    tick();
    chk("abort_drv", motor_drv, 0);
    chk("abort_flags", flags, 3'b010);
    chk("abort_rem", remaining, 0);
    Motores = 3'b100;
    tick();
    chk("rerun_start_rem", remaining, 5);
    count_on(3'b100, n);
    chk("rerun_on_cycles", n, 20);
    chk("rerun_flags", flags, 3'b110);
    Motores = 3'b000;
    tick();
    do_load(3, 2, 1);
    Motores = 3'b100;
    tick(); tick(); tick();
    amt_r = 9; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load_in_run_rem", remaining, 3);
    chk("load_in_run_busy", busy, 1);
    Motores = 3'b110;
    tick();
    chk("err_set", error, 1);
    chk("err_drv", motor_drv, 0);
    chk("err_rem", remaining, 0);
    chk("err_busy", busy, 0);
    chk("err_flags", flags, 0);
    Motores = 3'b000;
    tick();
    Motores = 3'b100;
    tick();
    count_on(3'b100, n);
    chk("amt_kept_cycles", n, 12);
    chk("err_sticky", error, 1);
    Motores = 3'b000;
    tick();
    do_load(3, 0, 1);
    chk("load_clr_err", error, 0);
    chk("load_clr_flags", flags, 0);
    Motores = 3'b010;
    tick();
    Motores = 3'b000;
    tick();
    Motores = 3'b100;
    tick();
    chk("pre_arst_drv", motor_drv, 3'b100);
    chk("pre_arst_flags", flags, 3'b010);
    #2 reset = 1'b1;
    #1;
    chk("arst_drv", motor_drv, 0);
    chk("arst_flags", flags, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rem", remaining, 0);
    tick();
    reset = 1'b0;
    Motores = 3'b000;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
